whirlpool_theta_seq: RTL



---
 rtl/whirlpool_pkg.sv | 20 ++
 rtl/whirlpool_theta_row.sv | 14 +
 rtl/whirlpool_theta_seq.sv | 82 ++++++++
 3 files changed

// File: rtl/whirlpool_pkg.sv
// whirlpool_pkg: shared widths, GF(2^8) constants, theta circulant coefficients and FSM states
package whirlpool_pkg;
  localparam int ROW_W = 64;
  localparam int BYTE_W = 8;
  localparam int STATE_W = 512;
  localparam logic [8:0] GF_POLY = 9'h11D;
  localparam logic [7:0] THETA_C [8] = '{8'd1, 8'd9, 8'd2, 8'd5, 8'd8, 8'd1, 8'd4, 8'd1};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic [BYTE_W-1:0] gf_mul8(input logic [BYTE_W-1:0] b, input logic [BYTE_W-1:0] c);
    logic [BYTE_W-1:0] a;
    logic [BYTE_W-1:0] r;
    a = b;
    r = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (c[i]) r ^= a;
      a = a[7] ? ((a << 1) ^ GF_POLY[7:0]) : (a << 1);
    end
    return r;
  endfunction
endpackage

// File: rtl/whirlpool_theta_row.sv
// whirlpool_theta_row: combinational theta of one 64-bit row (row_i in, row_o out, byte 0 = MSB)
module whirlpool_theta_row
  import whirlpool_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  output logic [ROW_W-1:0] row_o
);
  always_comb begin
    row_o = '0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 8; k++)
        row_o[63-8*j -: 8] ^= gf_mul8(row_i[63-8*((j+k)%8) -: 8], THETA_C[k]);
  end
endmodule

// File: rtl/whirlpool_theta_seq.sv
// whirlpool_theta_seq: sequential Whirlpool theta over a 512-bit state, LANES rows per clock; THETA_PI_EN folds pi into capture
// Ports: clk, rst (async, active-high), in_valid/in_ready/in_data (512), out_valid/out_ready/out_data (512)
module whirlpool_theta_seq
  import whirlpool_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);
  localparam int R = 8 / LANES;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("whirlpool_theta_seq: LANES must be 1, 2, 4 or 8");
  end
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0][ROW_W-1:0] data_q, data_d, cap;
  logic [LANES-1:0][2:0] lane_idx;
  logic [LANES-1:0][ROW_W-1:0] lane_row;
  logic accept;
  assign in_ready = !rst && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign out_data = data_q;
`ifdef THETA_PI_EN
  // packed row index 7-i holds row i; column j is rotated down by j rows
  always_comb begin
    cap = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        cap[7-i][63-8*j -: 8] = in_data[511-64*((i-j+8)%8)-8*j -: 8];
  end
`else
  assign cap = in_data;
`endif
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 3'(int'(cnt_q) * LANES + l);
    whirlpool_theta_row u_row (
      .row_i(data_q[3'd7 - lane_idx[l]]),
      .row_o(lane_row[l])
    );
  end
  always_comb begin
    data_d = data_q;
    for (int l = 0; l < LANES; l++) data_d[3'd7 - lane_idx[l]] = lane_row[l];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          data_q <= cap;
          cnt_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          data_q <= data_d;
          cnt_q <= cnt_q + 1'b1;
          state_q <= (cnt_q == CW'(R - 1)) ? DONE : RUN;
        end
        DONE: if (out_ready) begin
          if (in_valid) begin
            data_q <= cap;
            cnt_q <= '0;
          end
          state_q <= in_valid ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
